id_stage_pipe: RTL and testbench

Parametrised, pipelined instruction-decode stage for the RV32 core: register file read, opcode-driven immediate generation, load-use stall detection and a registered ID/EX output with valid/ready handshake. It sits between the IF stage and EX. It replaces the combinational decode path, which had an externally supplied immediate-select. It adds write-through bypass, RV32E register-count support, flush, and operand refresh while the output is held.

---
 rtl/id_stage_pipe.sv | 215 +++++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe.sv
// Instruction-decode stage: register file read with optional write-through
// bypass, opcode-driven immediate generation, load-use stall detection and a
// registered ID/EX entry behind a valid/ready handshake.
module id_stage_pipe #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned REG_NUM = 32,
    parameter bit          BYPASS  = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_load_valid,
    input  logic [4:0]      ex_load_rd,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_rs1_data,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic            out_is_load,
    output logic            out_illegal
);

    localparam int unsigned IDX_W   = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
    localparam logic [5:0]  REG_LIM = 6'(REG_NUM);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [XLEN-1:0] rf [REG_NUM];

    logic [6:0]        opcode_c;
    logic [4:0]        rd_c;
    logic [2:0]        funct3_c;
    logic [4:0]        rs1_c;
    logic [4:0]        rs2_c;
    logic [6:0]        funct7_c;
    logic signed [31:0] imm32_c;
    logic [XLEN-1:0]   imm_c;
    logic              rs1_used_c;
    logic              rs2_used_c;
    logic              rd_used_c;
    logic              known_c;
    logic              illegal_c;
    logic              stall_c;
    logic [XLEN-1:0]   rs1_data_c;
    logic [XLEN-1:0]   rs2_data_c;

    function automatic logic idx_oob(input logic [4:0] idx);
        return {1'b0, idx} >= REG_LIM;
    endfunction

    // Architectural read: x0 and out-of-range indices read zero; optional same-cycle forwarding.
    function automatic logic [XLEN-1:0] rf_read(input logic [4:0] idx);
        logic [XLEN-1:0] val;
        val = '0;
        if (idx != 5'd0 && !idx_oob(idx)) begin
            if (BYPASS && wb_we && wb_rd == idx) begin
                val = wb_data;
            end else begin
                val = rf[idx[IDX_W-1:0]];
            end
        end
        return val;
    endfunction

    assign opcode_c = in_inst[6:0];
    assign rd_c     = in_inst[11:7];
    assign funct3_c = in_inst[14:12];
    assign rs1_c    = in_inst[19:15];
    assign rs2_c    = in_inst[24:20];
    assign funct7_c = in_inst[31:25];

    // Format classification, immediate assembly and operand-usage flags.
    always_comb begin
        imm32_c    = '0;
        rs1_used_c = 1'b0;
        rs2_used_c = 1'b0;
        rd_used_c  = 1'b0;
        known_c    = 1'b0;
        case (opcode_c)
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
                imm32_c    = {{20{in_inst[31]}}, in_inst[31:20]};
                rs1_used_c = 1'b1;
                rd_used_c  = 1'b1;
                known_c    = 1'b1;
            end
            OP_STORE: begin
                imm32_c    = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
                rs1_used_c = 1'b1;
                rs2_used_c = 1'b1;
                known_c    = 1'b1;
            end
            OP_BRANCH: begin
                imm32_c    = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                              in_inst[30:25], in_inst[11:8], 1'b0};
                rs1_used_c = 1'b1;
                rs2_used_c = 1'b1;
                known_c    = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                imm32_c   = {in_inst[31:12], 12'b0};
                rd_used_c = 1'b1;
                known_c   = 1'b1;
            end
            OP_JAL: begin
                imm32_c   = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                             in_inst[20], in_inst[30:21], 1'b0};
                rd_used_c = 1'b1;
                known_c   = 1'b1;
            end
            OP_REG: begin
                rs1_used_c = 1'b1;
                rs2_used_c = 1'b1;
                rd_used_c  = 1'b1;
                known_c    = 1'b1;
            end
            default: begin
                known_c = 1'b0;
            end
        endcase
    end

    assign imm_c     = XLEN'(imm32_c);
    assign illegal_c = ~known_c
                     | (rs1_used_c & idx_oob(rs1_c))
                     | (rs2_used_c & idx_oob(rs2_c))
                     | (rd_used_c  & idx_oob(rd_c));

    assign stall_c = ex_load_valid & (ex_load_rd != 5'd0)
                   & ((rs1_used_c & (rs1_c == ex_load_rd))
                    | (rs2_used_c & (rs2_c == ex_load_rd)));

    assign in_ready = ~flush & ~stall_c & (~out_valid | out_ready);

    assign rs1_data_c = rf_read(rs1_c);
    assign rs2_data_c = rf_read(rs2_c);

    // Register file write port; x0 and out-of-range destinations are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(REG_NUM); i++) begin
                rf[i] <= '0;
            end
        end else if (wb_we && wb_rd != 5'd0 && !idx_oob(wb_rd)) begin
            rf[wb_rd[IDX_W-1:0]] <= wb_data;
        end
    end

    // ID/EX entry: flush, then load, then drain, otherwise hold with operand refresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_rs1_data <= '0;
            out_rs2_data <= '0;
            out_imm      <= '0;
            out_rs1      <= '0;
            out_rs2      <= '0;
            out_rd       <= '0;
            out_opcode   <= '0;
            out_funct3   <= '0;
            out_funct7   <= '0;
            out_is_load  <= 1'b0;
            out_illegal  <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid    <= 1'b1;
            out_pc       <= in_pc;
            out_rs1_data <= rs1_data_c;
            out_rs2_data <= rs2_data_c;
            out_imm      <= imm_c;
            out_rs1      <= rs1_c;
            out_rs2      <= rs2_c;
            out_rd       <= rd_c;
            out_opcode   <= opcode_c;
            out_funct3   <= funct3_c;
            out_funct7   <= funct7_c;
            out_is_load  <= (opcode_c == OP_LOAD);
            out_illegal  <= illegal_c;
        end else if (out_ready && out_valid) begin
            out_valid <= 1'b0;
        end else if (out_valid) begin
            if (wb_we && wb_rd != 5'd0 && wb_rd == out_rs1) begin
                out_rs1_data <= wb_data;
            end
            if (wb_we && wb_rd != 5'd0 && wb_rd == out_rs2) begin
                out_rs2_data <= wb_data;
            end
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: an RV32I/bypass instance and an RV32E/no-bypass
// instance share stimulus and are compared against a behavioural model.
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_load_valid;
    logic [4:0]  ex_load_rd;
    logic        flush;
    logic        out_ready;

    logic [1:0]       rdy_o, vo, ldo, ilo;
    logic [1:0][31:0] pco, ado, bdo, imo;
    logic [1:0][4:0]  s1o, s2o, rdo;
    logic [1:0][6:0]  opo, f7o;
    logic [1:0][2:0]  f3o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_stage_pipe #(.XLEN(32), .REG_NUM(32), .BYPASS(1'b1)) dut_i (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_o[0]),
        .in_inst(in_inst), .in_pc(in_pc), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd),
        .flush(flush), .out_valid(vo[0]), .out_ready(out_ready), .out_pc(pco[0]),
        .out_rs1_data(ado[0]), .out_rs2_data(bdo[0]), .out_imm(imo[0]),
        .out_rs1(s1o[0]), .out_rs2(s2o[0]), .out_rd(rdo[0]), .out_opcode(opo[0]),
        .out_funct3(f3o[0]), .out_funct7(f7o[0]), .out_is_load(ldo[0]),
        .out_illegal(ilo[0])
    );

    id_stage_pipe #(.XLEN(32), .REG_NUM(16), .BYPASS(1'b0)) dut_e (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_o[1]),
        .in_inst(in_inst), .in_pc(in_pc), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd),
        .flush(flush), .out_valid(vo[1]), .out_ready(out_ready), .out_pc(pco[1]),
        .out_rs1_data(ado[1]), .out_rs2_data(bdo[1]), .out_imm(imo[1]),
        .out_rs1(s1o[1]), .out_rs2(s2o[1]), .out_rd(rdo[1]), .out_opcode(opo[1]),
        .out_funct3(f3o[1]), .out_funct7(f7o[1]), .out_is_load(ldo[1]),
        .out_illegal(ilo[1])
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] r1d;
        logic [31:0] r2d;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        ld;
        logic        ill;
    } ent_t;

    ent_t        m [2];
    logic [31:0] mrf [2][32];

    // Format codes: 0=R 1=I 2=S 3=B 4=U 5=J, -1 unknown.
    function automatic int fmt_of(input logic [6:0] op);
        case (op)
            7'h13, 7'h03, 7'h67, 7'h73: return 1;
            7'h23:                      return 2;
            7'h63:                      return 3;
            7'h37, 7'h17:               return 4;
            7'h6F:                      return 5;
            7'h33:                      return 0;
            default:                    return -1;
        endcase
    endfunction

    function automatic logic [31:0] imm_of(input logic [31:0] inst);
        int s;
        s = int'(inst);
        case (fmt_of(inst[6:0]))
            1: return 32'(s >>> 20);
            2: return 32'(((s >>> 25) << 5) | int'(inst[11:7]));
            3: return 32'(((s >>> 31) << 12) | (int'(inst[7]) << 11)
                          | (int'(inst[30:25]) << 5) | (int'(inst[11:8]) << 1));
            4: return inst & 32'hFFFF_F000;
            5: return 32'(((s >>> 31) << 20) | (int'(inst[19:12]) << 12)
                          | (int'(inst[20]) << 11) | (int'(inst[30:21]) << 1));
            default: return 32'd0;
        endcase
    endfunction

    function automatic int rn_of(input int k);
        return (k == 0) ? 32 : 16;
    endfunction

    function automatic bit rs1u(input int f); return f inside {0, 1, 2, 3}; endfunction
    function automatic bit rs2u(input int f); return f inside {0, 2, 3};    endfunction
    function automatic bit rdu (input int f); return f inside {0, 1, 4, 5}; endfunction

    function automatic logic [31:0] mread(input int k, input logic [4:0] idx);
        if (idx == 5'd0 || int'(idx) >= rn_of(k)) return 32'd0;
        if (k == 0 && wb_we && wb_rd == idx) return wb_data;
        return mrf[k][idx];
    endfunction

    function automatic bit mstall();
        int f;
        f = fmt_of(in_inst[6:0]);
        return ex_load_valid && ex_load_rd != 5'd0 &&
               ((rs1u(f) && in_inst[19:15] == ex_load_rd) ||
                (rs2u(f) && in_inst[24:20] == ex_load_rd));
    endfunction

    function automatic bit mready(input int k);
        return !flush && !mstall() && (!m[k].valid || out_ready);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m[k] = '0;
            for (int r = 0; r < 32; r++) mrf[k][r] = 32'd0;
        end
    endtask

    // One clock edge of the reference behaviour, evaluated with pre-edge inputs.
    task automatic model_update();
        bit rdy [2];
        int f;
        for (int k = 0; k < 2; k++) rdy[k] = mready(k);
        f = fmt_of(in_inst[6:0]);
        for (int k = 0; k < 2; k++) begin
            if (flush) begin
                m[k].valid = 1'b0;
            end else if (in_valid && rdy[k]) begin
                m[k].valid = 1'b1;
                m[k].pc    = in_pc;
                m[k].r1d   = mread(k, in_inst[19:15]);
                m[k].r2d   = mread(k, in_inst[24:20]);
                m[k].imm   = imm_of(in_inst);
                m[k].rs1   = in_inst[19:15];
                m[k].rs2   = in_inst[24:20];
                m[k].rd    = in_inst[11:7];
                m[k].op    = in_inst[6:0];
                m[k].f3    = in_inst[14:12];
                m[k].f7    = in_inst[31:25];
                m[k].ld    = (in_inst[6:0] == 7'h03);
                m[k].ill   = (f < 0)
                           || (rs1u(f) && int'(in_inst[19:15]) >= rn_of(k))
                           || (rs2u(f) && int'(in_inst[24:20]) >= rn_of(k))
                           || (rdu(f)  && int'(in_inst[11:7])  >= rn_of(k));
            end else if (out_ready && m[k].valid) begin
                m[k].valid = 1'b0;
            end else if (m[k].valid && wb_we && wb_rd != 5'd0) begin
                if (wb_rd == m[k].rs1) m[k].r1d = wb_data;
                if (wb_rd == m[k].rs2) m[k].r2d = wb_data;
            end
            if (wb_we && wb_rd != 5'd0 && int'(wb_rd) < rn_of(k)) mrf[k][wb_rd] = wb_data;
        end
    endtask

    function automatic ent_t dut_ent(input int k);
        ent_t e;
        e.valid = vo[k];  e.pc  = pco[k]; e.r1d = ado[k]; e.r2d = bdo[k];
        e.imm   = imo[k]; e.rs1 = s1o[k]; e.rs2 = s2o[k]; e.rd  = rdo[k];
        e.op    = opo[k]; e.f3  = f3o[k]; e.f7  = f7o[k]; e.ld  = ldo[k];
        e.ill   = ilo[k];
        return e;
    endfunction

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chke(input string nm, input ent_t act, input ent_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Inputs are driven just after a falling edge; checks straddle the next rising edge.
    task automatic step(input string tag);
        #1;
        for (int k = 0; k < 2; k++)
            chk32($sformatf("%s in_ready%0d", tag, k), 32'(rdy_o[k]), 32'(mready(k)));
        @(posedge clk);
        model_update();
        #1;
        for (int k = 0; k < 2; k++)
            chke($sformatf("%s entry%0d", tag, k), dut_ent(k), m[k]);
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0; in_inst = 32'd0; in_pc = 32'd0;
        wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
        ex_load_valid = 1'b0; ex_load_rd = 5'd0; flush = 1'b0; out_ready = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) chke($sformatf("reset entry%0d", k), dut_ent(k), '0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [31:0] inst;
        logic [31:0] imm;
        logic        ill_i;
        logic        ill_e;
        logic        ld;
    } vec_t;

    localparam logic [31:0] ADD_7_5_6  = 32'h0062_83B3;
    localparam logic [31:0] ADDI_6_5_M1 = 32'hFFF2_8313;
    localparam logic [31:0] ADD_7_8_9  = 32'h0094_03B3;

    vec_t        vecs [11];
    logic [6:0]  ops  [12];
    logic [31:0] ri;

    initial begin
        vecs[0]  = '{32'hFE20_AE23, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0}; // sw x2,-4(x1)
        vecs[1]  = '{32'hFE20_8CE3, 32'hFFFF_FFF8, 1'b0, 1'b0, 1'b0}; // beq x1,x2,-8
        vecs[2]  = '{32'h1234_51B7, 32'h1234_5000, 1'b0, 1'b0, 1'b0}; // lui x3,0x12345
        vecs[3]  = '{32'h0010_00EF, 32'h0000_0800, 1'b0, 1'b0, 1'b0}; // jal x1,+2048
        vecs[4]  = '{32'h0020_88B3, 32'h0000_0000, 1'b0, 1'b1, 1'b0}; // add x17,x1,x2
        vecs[5]  = '{32'h1234_507F, 32'h0000_0000, 1'b1, 1'b1, 1'b0}; // opcode 0x7F
        vecs[6]  = '{32'h0041_2403, 32'h0000_0004, 1'b0, 1'b0, 1'b1}; // lw x8,4(x2)
        vecs[7]  = '{32'hFFFF_F217, 32'hFFFF_F000, 1'b0, 1'b0, 1'b0}; // auipc x4,0xFFFFF
        vecs[8]  = '{32'h0000_8067, 32'h0000_0000, 1'b0, 1'b0, 1'b0}; // jalr x0,0(x1)
        vecs[9]  = '{ADD_7_5_6,     32'h0000_0000, 1'b0, 1'b0, 1'b0}; // add x7,x5,x6
        vecs[10] = '{32'h0009_0F93, 32'h0000_0000, 1'b0, 1'b1, 1'b0}; // addi x31,x18,0
        ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63,
                7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F, 7'h0B};

        rst_n = 1'b0;
        idle();
        model_reset();
        @(negedge clk);
        do_reset();

        // Fresh register file reads zero.
        in_valid = 1'b1; in_inst = ADD_7_5_6; in_pc = 32'h100;
        step("read_x5");
        chk32("read_x5 rs1_data", ado[0], 32'd0);

        // Write-back and decode of the same register in one cycle.
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234;
        in_inst = ADDI_6_5_M1; in_pc = 32'h104;
        step("bypass");
        chk32("bypass rs1_data", ado[0], 32'h1234);
        chk32("bypass imm", imo[0], 32'hFFFF_FFFF);
        chk32("bypass rd", 32'(rdo[0]), 32'd6);
        chk32("nobypass rs1_data", ado[1], 32'd0);
        wb_we = 1'b0;

        // Load-use hazard: bubble, then accept once the load leaves EX.
        in_inst = ADD_7_5_6; in_pc = 32'h108;
        ex_load_valid = 1'b1; ex_load_rd = 5'd5;
        #1 chk32("stall in_ready", 32'(rdy_o[0]), 32'd0);
        step("stall");
        chk32("stall bubble", 32'(vo[0]), 32'd0);
        ex_load_valid = 1'b0;
        step("unstall");
        chk32("unstall valid", 32'(vo[0]), 32'd1);
        chk32("unstall rd", 32'(rdo[0]), 32'd7);
        chk32("unstall rs1_data", ado[0], 32'h1234);

        // Backpressure: held entry picks up a late write to its rs2.
        in_valid = 1'b0;
        step("drain");
        in_valid = 1'b1; in_inst = ADD_7_8_9; in_pc = 32'h10C; out_ready = 1'b0;
        step("hold_load");
        in_inst = ADDI_6_5_M1; wb_we = 1'b1; wb_rd = 5'd9; wb_data = 32'hCAFE;
        #1 chk32("hold in_ready", 32'(rdy_o[0]), 32'd0);
        step("refresh");
        chk32("refresh rs2_data", bdo[0], 32'hCAFE);
        chk32("refresh rs2_data e", bdo[1], 32'hCAFE);
        chk32("refresh rd", 32'(rdo[0]), 32'd7);
        chk32("refresh pc", pco[0], 32'h10C);
        chk32("refresh valid", 32'(vo[0]), 32'd1);
        wb_we = 1'b0;

        // Flush kills the held entry and the incoming instruction.
        flush = 1'b1;
        #1 chk32("flush in_ready", 32'(rdy_o[0]), 32'd0);
        step("flush");
        chk32("flush valid", 32'(vo[0]), 32'd0);
        flush = 1'b0; out_ready = 1'b1;

        // Immediate / illegal table.
        for (int i = 0; i < 11; i++) begin
            in_valid = 1'b1; in_inst = vecs[i].inst; in_pc = 32'h200 + 32'(i * 4);
            step($sformatf("vec%0d", i));
            chk32($sformatf("vec%0d imm", i), imo[0], vecs[i].imm);
            chk32($sformatf("vec%0d ill", i), 32'(ilo[0]), 32'(vecs[i].ill_i));
            chk32($sformatf("vec%0d ill_e", i), 32'(ilo[1]), 32'(vecs[i].ill_e));
            chk32($sformatf("vec%0d ld", i), 32'(ldo[0]), 32'(vecs[i].ld));
        end

        // Randomised traffic, with an occasional reset mid-transfer.
        for (int n = 0; n < 3000; n++) begin
            ri = $urandom;
            ri[6:0] = ops[$urandom_range(0, 11)];
            if ($urandom_range(0, 3) != 0) begin
                ri[11:7]  = 5'($urandom_range(0, 7));
                ri[19:15] = 5'($urandom_range(0, 7));
                ri[24:20] = 5'($urandom_range(0, 7));
            end
            in_inst       = ri;
            in_pc         = $urandom;
            in_valid      = ($urandom_range(0, 3) != 0);
            out_ready     = ($urandom_range(0, 3) != 0);
            flush         = ($urandom_range(0, 19) == 0);
            ex_load_valid = ($urandom_range(0, 3) == 0);
            ex_load_rd    = 5'($urandom_range(0, 7));
            wb_we         = ($urandom_range(0, 1) == 1);
            wb_rd         = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                        : 5'($urandom_range(0, 9));
            wb_data       = $urandom;
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                step($sformatf("rand%0d", n));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
